// File: rtl/gpio_pkg.sv
// Shared definitions for the Wishbone GPIO controller: register word offsets
// and the byte-lane helpers used by every register write.
package gpio_pkg;

  localparam logic [2:0] GPIO_OUT     = 3'd0;
  localparam logic [2:0] GPIO_IN      = 3'd1;
  localparam logic [2:0] GPIO_DIR     = 3'd2;
  localparam logic [2:0] GPIO_SET     = 3'd3;
  localparam logic [2:0] GPIO_CLR     = 3'd4;
  localparam logic [2:0] GPIO_RISE_EN = 3'd5;
  localparam logic [2:0] GPIO_FALL_EN = 3'd6;
  localparam logic [2:0] GPIO_STATUS  = 3'd7;

  // Expand the four byte selects into a 32-bit bit mask.
  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

  // Merge a write into an existing value: selected lanes take the new data,
  // unselected lanes keep the old value.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] m;
    m = sel_mask(sel);
    return (old_val & ~m) | (new_val & m);
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser followed by a one-cycle history flop; produces the
// synchronised value plus single-cycle rise/fall pulses per pin.
module gpio_sync_edge #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] chain_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  // Shift the pad value through the synchroniser chain and keep last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        chain_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      chain_q[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
      prev_q <= chain_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = chain_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q;
  assign fall     = ~sync_out & prev_q;

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone B4 classic GPIO slave: output/direction registers with atomic
// set/clear, synchronised inputs, and sticky edge interrupts on irq_o.
//
// Handshake: a request is cyc & stb while ack is low. Ack is a flop raised on
// the edge that samples the request and held for exactly one cycle; writes
// commit on that same edge and read data is presented only while ack is high
// (zero otherwise). A master that drops cyc/stb before that edge gets nothing.
module wb_gpio_irq
  import gpio_pkg::*;
#(
  parameter int GPIO_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe_o,
  output logic                  irq_o
);

  localparam int W = GPIO_WIDTH;

  logic         req;
  logic         wr;
  logic [2:0]   off;
  logic [31:0]  wmask;
  logic [31:0]  cur_val;
  logic [31:0]  merged;
  logic [31:0]  rdata;
  logic         adr_unused;

  logic [W-1:0] in_sync, rise, fall;
  logic [W-1:0] out_q, dir_q, rise_en_q, fall_en_q, status_q;
  logic [W-1:0] out_n, dir_n, rise_en_n, fall_en_n, status_n;
  logic [W-1:0] w1c, events;

  assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr         = req & wb_we_i;
  assign off        = wb_adr_i[4:2];
  assign wmask      = wb_dat_i & sel_mask(wb_sel_i);
  assign adr_unused = ^{wb_adr_i[ADDR_WIDTH-1:5], wb_adr_i[1:0]};

  gpio_sync_edge #(
    .WIDTH      (W),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .async_in(gpio_i),
    .sync_out(in_sync),
    .rise    (rise),
    .fall    (fall)
  );

  assign events = (rise & rise_en_q) | (fall & fall_en_q);

  // Read mux; write-only registers read back as zero.
  always_comb begin
    rdata = '0;
    case (off)
      GPIO_OUT:     rdata = 32'(out_q);
      GPIO_IN:      rdata = 32'(in_sync);
      GPIO_DIR:     rdata = 32'(dir_q);
      GPIO_RISE_EN: rdata = 32'(rise_en_q);
      GPIO_FALL_EN: rdata = 32'(fall_en_q);
      GPIO_STATUS:  rdata = 32'(status_q);
      default:      rdata = '0;
    endcase
  end

  // Next-state for every register; lane merging keeps unselected bytes.
  always_comb begin
    cur_val   = '0;
    out_n     = out_q;
    dir_n     = dir_q;
    rise_en_n = rise_en_q;
    fall_en_n = fall_en_q;
    w1c       = '0;
    case (off)
      GPIO_OUT:     cur_val = 32'(out_q);
      GPIO_DIR:     cur_val = 32'(dir_q);
      GPIO_RISE_EN: cur_val = 32'(rise_en_q);
      GPIO_FALL_EN: cur_val = 32'(fall_en_q);
      default:      cur_val = '0;
    endcase
    merged = apply_sel(cur_val, wb_dat_i, wb_sel_i);
    if (wr) begin
      case (off)
        GPIO_OUT:     out_n     = merged[W-1:0];
        GPIO_DIR:     dir_n     = merged[W-1:0];
        GPIO_SET:     out_n     = out_q | wmask[W-1:0];
        GPIO_CLR:     out_n     = out_q & ~wmask[W-1:0];
        GPIO_RISE_EN: rise_en_n = merged[W-1:0];
        GPIO_FALL_EN: fall_en_n = merged[W-1:0];
        GPIO_STATUS:  w1c       = wmask[W-1:0];
        default:      out_n     = out_q;
      endcase
    end
    // A fresh event beats a same-cycle clear.
    status_n = (status_q & ~w1c) | events;
  end

  // Register state, ack pulse and ack-cycle read data.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
    end else begin
      wb_ack_o  <= req;
      wb_dat_o  <= (req && !wb_we_i) ? rdata : 32'h0;
      out_q     <= out_n;
      dir_q     <= dir_n;
      rise_en_q <= rise_en_n;
      fall_en_q <= fall_en_n;
      status_q  <= status_n;
    end
  end

  assign gpio_o    = out_q;
  assign gpio_oe_o = dir_q;
  assign irq_o     = |status_q;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Bench for wb_gpio_irq: a 32-pin and an 8-pin instance on a shared bus,
// table-driven register accesses plus timed edge/interrupt sequences.
module tb_wb_gpio_irq;
  import gpio_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst_n8;
  logic        cyc32, stb32, cyc8, stb8, we;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic [31:0] dat32, dat8;
  logic        ack32, ack8, irq32, irq8;
  logic [31:0] gin32, gout32, goe32;
  logic [7:0]  gin8, gout8, goe8;

  wb_gpio_irq #(.GPIO_WIDTH(32), .SYNC_STAGES(2), .ADDR_WIDTH(32)) dut32 (
    .clk_i(clk), .rst_n_i(rst_n), .wb_cyc_i(cyc32), .wb_stb_i(stb32),
    .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_dat_o(dat32), .wb_ack_o(ack32), .gpio_i(gin32), .gpio_o(gout32),
    .gpio_oe_o(goe32), .irq_o(irq32));

  wb_gpio_irq #(.GPIO_WIDTH(8), .SYNC_STAGES(2), .ADDR_WIDTH(32)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n8), .wb_cyc_i(cyc8), .wb_stb_i(stb8),
    .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_dat_o(dat8), .wb_ack_o(ack8), .gpio_i(gin8), .gpio_o(gout8),
    .gpio_oe_o(goe8), .irq_o(irq8));

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp8_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pop an expected read word for every ack; data must be zero outside ack.
  always @(negedge clk) begin
    if (ack32) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL ack32_unexpected: got ack with empty queue at %0t", $time);
      end else check("rd32", dat32, exp_q.pop_front());
    end else if (dat32 !== 32'h0) begin
      n_cmp++; n_fail++;
      $display("FAIL dat32_idle: got %h expected 00000000 at %0t", dat32, $time);
    end
    if (ack8) begin
      if (exp8_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL ack8_unexpected: got ack with empty queue at %0t", $time);
      end else check("rd8", dat8, exp8_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; leaves at the negedge one cycle after the ack cycle.
  task automatic wb_access(input bit d8, input logic w, input logic [2:0] off,
                           input logic [31:0] d, input logic [3:0] s,
                           input logic [31:0] exp_rd);
    if (d8) exp8_q.push_back(w ? 32'h0 : exp_rd);
    else    exp_q.push_back(w ? 32'h0 : exp_rd);
    we = w; adr = {27'b0, off, 2'b00}; wdat = d; sel = s;
    if (d8) begin cyc8 = 1'b1; stb8 = 1'b1; end
    else    begin cyc32 = 1'b1; stb32 = 1'b1; end
    @(posedge clk); @(negedge clk);
    check(d8 ? "ack8_rise" : "ack32_rise", 32'(d8 ? ack8 : ack32), 32'h1);
    cyc32 = 1'b0; stb32 = 1'b0; cyc8 = 1'b0; stb8 = 1'b0; we = 1'b0;
    @(posedge clk); @(negedge clk);
    check(d8 ? "ack8_single" : "ack32_single", 32'(d8 ? ack8 : ack32), 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  off;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[$];

  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      wb_access(1'b0, vt[i].we, vt[i].off, vt[i].dat, vt[i].sel, vt[i].exp_rd);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset reads of all eight offsets.
    for (int i = 0; i < 8; i++) vt.push_back(vec_t'{1'b0, 3'(i), 32'h0, 4'hF, 32'h0});
    // Basic OUT/DIR/SET/CLR (entries 8..15).
    vt.push_back(vec_t'{1'b1, GPIO_OUT, 32'hA5A5A5A5, 4'hF, 32'h0});
    vt.push_back(vec_t'{1'b1, GPIO_DIR, 32'hFFFF0000, 4'hF, 32'h0});
    vt.push_back(vec_t'{1'b1, GPIO_SET, 32'h0000000F, 4'hF, 32'h0});
    vt.push_back(vec_t'{1'b1, GPIO_CLR, 32'hA0000000, 4'hF, 32'h0});
    vt.push_back(vec_t'{1'b0, GPIO_OUT, 32'h0, 4'hF, 32'h05A5A5AF});
    vt.push_back(vec_t'{1'b0, GPIO_DIR, 32'h0, 4'hF, 32'hFFFF0000});
    vt.push_back(vec_t'{1'b0, GPIO_SET, 32'h0, 4'hF, 32'h0});
    vt.push_back(vec_t'{1'b0, GPIO_CLR, 32'h0, 4'hF, 32'h0});
    // Byte lanes, read-only and enable registers (entries 16..31).
    vt.push_back(vec_t'{1'b1, GPIO_OUT, 32'h00000000, 4'hF, 32'h0});
    vt.push_back(vec_t'{1'b1, GPIO_OUT, 32'hFFFFFFFF, 4'b0010, 32'h0});
    vt.push_back(vec_t'{1'b0, GPIO_OUT, 32'h0, 4'hF, 32'h0000FF00});
    vt.push_back(vec_t'{1'b1, GPIO_SET, 32'hFFFFFFFF, 4'b0001, 32'h0});
    vt.push_back(vec_t'{1'b0, GPIO_OUT, 32'h0, 4'hF, 32'h0000FFFF});
    vt.push_back(vec_t'{1'b1, GPIO_CLR, 32'hFFFFFFFF, 4'b0010, 32'h0});
    vt.push_back(vec_t'{1'b0, GPIO_OUT, 32'h0, 4'hF, 32'h000000FF});
    vt.push_back(vec_t'{1'b1, GPIO_OUT, 32'h12345678, 4'hF, 32'h0});
    vt.push_back(vec_t'{1'b1, GPIO_OUT, 32'hFFFFFFFF, 4'b1000, 32'h0});
    vt.push_back(vec_t'{1'b0, GPIO_OUT, 32'h0, 4'hF, 32'hFF345678});
    vt.push_back(vec_t'{1'b1, GPIO_IN, 32'hFFFFFFFF, 4'hF, 32'h0});
    vt.push_back(vec_t'{1'b0, GPIO_IN, 32'h0, 4'hF, 32'h0});
    vt.push_back(vec_t'{1'b1, GPIO_STATUS, 32'hFFFFFFFF, 4'hF, 32'h0});
    vt.push_back(vec_t'{1'b0, GPIO_STATUS, 32'h0, 4'hF, 32'h0});
    vt.push_back(vec_t'{1'b1, GPIO_RISE_EN, 32'h00000001, 4'hF, 32'h0});
    vt.push_back(vec_t'{1'b0, GPIO_RISE_EN, 32'h0, 4'hF, 32'h00000001});

    rst_n = 1'b0; rst_n8 = 1'b0;
    cyc32 = 1'b0; stb32 = 1'b0; cyc8 = 1'b0; stb8 = 1'b0; we = 1'b0;
    adr = '0; wdat = '0; sel = '0; gin32 = '0; gin8 = '0;
    wait_cycles(3);
    check("rst_ack32", 32'(ack32), 32'h0);
    rst_n = 1'b1; rst_n8 = 1'b1;
    wait_cycles(1);
    check("rst_gpio_o", gout32, 32'h0);
    check("rst_gpio_oe", goe32, 32'h0);
    check("rst_irq", 32'(irq32), 32'h0);
    check("rst_dat", dat32, 32'h0);

    run_vec(0, 16);
    check("basic_gpio_o", gout32, 32'h05A5A5AF);
    check("basic_gpio_oe", goe32, 32'hFFFF0000);
    run_vec(16, vt.size());
    check("lanes_gpio_o", gout32, 32'hFF345678);

    // Rise on pin 0: irq exactly SYNC_STAGES+1 edges after the change.
    gin32[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("rise_lat_e%0d", k), 32'(irq32), 32'(k == 3));
    end
    wb_access(1'b0, 1'b0, GPIO_STATUS, 32'h0, 4'hF, 32'h00000001);
    wb_access(1'b0, 1'b0, GPIO_IN, 32'h0, 4'hF, 32'h00000001);
    wb_access(1'b0, 1'b1, GPIO_STATUS, 32'h00000001, 4'hF, 32'h0);
    check("w1c_irq_low", 32'(irq32), 32'h0);
    wb_access(1'b0, 1'b0, GPIO_STATUS, 32'h0, 4'hF, 32'h0);

    // Fall on pin 1 sets status; then a second fall collides with W1C.
    gin32[1] = 1'b1;
    wait_cycles(5);
    wb_access(1'b0, 1'b1, GPIO_FALL_EN, 32'h00000002, 4'hF, 32'h0);
    gin32[1] = 1'b0;
    wait_cycles(4);
    wb_access(1'b0, 1'b0, GPIO_STATUS, 32'h0, 4'hF, 32'h00000002);
    check("fall_irq", 32'(irq32), 32'h1);
    gin32[1] = 1'b1;
    wait_cycles(5);
    gin32[1] = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    wb_access(1'b0, 1'b1, GPIO_STATUS, 32'h00000002, 4'hF, 32'h0);
    check("race_irq", 32'(irq32), 32'h1);
    wb_access(1'b0, 1'b0, GPIO_STATUS, 32'h0, 4'hF, 32'h00000002);

    // Disabling an enable keeps the pending bit; W1C then clears it.
    wb_access(1'b0, 1'b1, GPIO_FALL_EN, 32'h0, 4'hF, 32'h0);
    wb_access(1'b0, 1'b0, GPIO_STATUS, 32'h0, 4'hF, 32'h00000002);
    wb_access(1'b0, 1'b1, GPIO_STATUS, 32'h00000002, 4'hF, 32'h0);
    wb_access(1'b0, 1'b0, GPIO_STATUS, 32'h0, 4'hF, 32'h0);
    check("clr_irq", 32'(irq32), 32'h0);

    // Enabling after an edge must not latch it; a later edge does.
    gin32[2] = 1'b1;
    wait_cycles(5);
    wb_access(1'b0, 1'b1, GPIO_RISE_EN, 32'h00000005, 4'hF, 32'h0);
    wb_access(1'b0, 1'b0, GPIO_STATUS, 32'h0, 4'hF, 32'h0);
    gin32[2] = 1'b0;
    wait_cycles(5);
    gin32[2] = 1'b1;
    wait_cycles(5);
    wb_access(1'b0, 1'b0, GPIO_STATUS, 32'h0, 4'hF, 32'h00000004);

    // Narrow instance: upper bits dropped, reset mid-write loses the access.
    wb_access(1'b1, 1'b1, GPIO_OUT, 32'hFFFFFFFF, 4'hF, 32'h0);
    wb_access(1'b1, 1'b0, GPIO_OUT, 32'h0, 4'hF, 32'h000000FF);
    check("w8_gpio_o", 32'(gout8), 32'h000000FF);
    wb_access(1'b1, 1'b1, GPIO_DIR, 32'hFFFFFF5A, 4'hF, 32'h0);
    wb_access(1'b1, 1'b0, GPIO_DIR, 32'h0, 4'hF, 32'h0000005A);
    check("w8_gpio_oe", 32'(goe8), 32'h0000005A);
    we = 1'b1; adr = {27'b0, GPIO_OUT, 2'b00}; wdat = 32'h0000003C; sel = 4'hF;
    cyc8 = 1'b1; stb8 = 1'b1;
    #2 rst_n8 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_mid_ack8", 32'(ack8), 32'h0);
    cyc8 = 1'b0; stb8 = 1'b0; we = 1'b0;
    check("rst_mid_gpio_o", 32'(gout8), 32'h0);
    rst_n8 = 1'b1;
    wait_cycles(1);
    wb_access(1'b1, 1'b0, GPIO_OUT, 32'h0, 4'hF, 32'h0);
    wb_access(1'b1, 1'b0, GPIO_DIR, 32'h0, 4'hF, 32'h0);

    wait_cycles(2);
    check("queue_drain", 32'(exp_q.size() + exp8_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_gpio_irq.md
Name: wb_gpio_irq

Overview:
Parametrised Wishbone B4 classic slave GPIO controller, the successor of the fixed 32-bit LED output block.
- Adds per-pin direction control, atomic set/clear writes and a synchronised input path.
- Detects rising/falling edges per pin and latches them into a sticky interrupt status with a single irq_o line.
- Sits on the system Wishbone interconnect; irq_o feeds one bit of the CPU irq vector.

Parameters:
GPIO_WIDTH, 32, number of pins (1..32); register bits above GPIO_WIDTH-1 read 0, writes ignored.
SYNC_STAGES, 2, input synchroniser depth (>=2).
ADDR_WIDTH, 32, width of wb_adr_i; only bits [4:2] are decoded.

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  reset, asynchronous, active-low
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_we_i  in  1  write enable
wb_adr_i  in  ADDR_WIDTH  byte address
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte selects
wb_dat_o  out  32  read data
wb_ack_o  out  1  acknowledge
gpio_i  in  GPIO_WIDTH  pad inputs (asynchronous)
gpio_o  out  GPIO_WIDTH  pad output values
gpio_oe_o  out  GPIO_WIDTH  pad output enables, 1 = drive; tristate buffer sits in the top level
irq_o  out  1  level interrupt, high while any status bit is set

Behaviour:
- Reset (async assert, sync release) clears every flop to 0; outputs at reset: wb_dat_o=0, wb_ack_o=0, gpio_o=0, gpio_oe_o=0, irq_o=0.
- Register map, word offset = wb_adr_i[4:2]:
  - 0 OUT: RW, drives gpio_o.
  - 1 IN: RO, synchronised inputs.
  - 2 DIR: RW, drives gpio_oe_o.
  - 3 SET: WO, OUT |= data; reads 0.
  - 4 CLR: WO, OUT &= ~data; reads 0.
  - 5 RISE_EN: RW.
  - 6 FALL_EN: RW.
  - 7 STATUS: RO, write-1-to-clear.
- Handshake:
  - wb_ack_o is registered. It asserts on the edge after cyc&stb&!ack and is high for exactly one cycle.
  - Every access is acked: 1 wait state, 2-cycle access.
  - wb_dat_o is valid in the ack cycle and is 0 otherwise.
  - Writes take effect on the same edge that raises ack.
  - Master dropping cyc/stb before ack: no ack is issued and no write occurs.
- Byte lanes: wb_sel_i[n] gates bits [8n+7:8n] for RW, SET, CLR and W1C writes. Unselected lanes are unchanged and not cleared.
- Input path:
  - gpio_i passes through a SYNC_STAGES flop chain, then one "prev" flop.
  - rise = sync & ~prev; fall = ~sync & prev.
- Status update:
  - STATUS[i] is set on the edge after (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]).
  - Latency from a gpio_i change to irq_o high is SYNC_STAGES+1 clock edges.
- irq_o = |STATUS, decoded from flops with no combinational path from any input.
- Boundary cases:
  - Same-cycle W1C and new event on the same bit: set wins, bit stays 1.
  - Same-cycle SET and CLR are impossible (single port).
  - Clearing an enable does not clear pending status.
  - Enabling does not retro-latch past edges.
  - Pin held high through reset produces a rise event after release. It is masked because RISE_EN=0 from reset.
  - Pulses shorter than one clock period may be missed (no guarantee).
  - Output pins (DIR=1) still feed IN and edge detection (readback/self-interrupt allowed).
  - Reset asserted mid-transaction: ack drops immediately and the transaction is lost.

Decomposition:
- Package gpio_pkg holds:
  - register offset constants (GPIO_OUT..GPIO_STATUS, 3-bit);
  - a function applying byte-select masks to a 32-bit write.
- Sub-module gpio_sync_edge (params WIDTH, SYNC_STAGES) contains the synchroniser, the prev flop and the rise/fall outputs.
- The top level holds the Wishbone FSM-free ack logic, the registers and the status.

Test Plan:
- Reset then read all 8 offsets -> all read 0x00000000; gpio_oe_o=0, irq_o=0; every access acked exactly once, 2 cycles after stb.
- Write OUT=0xA5A5A5A5, DIR=0xFFFF0000; SET 0x0000000F; CLR 0xA0000000 -> gpio_o=0x05A5A5AF, gpio_oe_o=0xFFFF0000, OUT reads 0x05A5A5AF.
- Write OUT=0xFFFFFFFF with sel=4'b0010 from reset -> OUT reads 0x0000FF00.
- RISE_EN=0x1, gpio_i[0] 0->1 -> irq_o high exactly 3 edges later, STATUS=0x1; W1C 0x1 -> irq_o low the edge after ack.
- FALL_EN=0x2, toggle gpio_i[1] 1->0 timed so the fall event lands on the W1C 0x2 write edge -> STATUS[1] stays 1, irq_o stays high.
- GPIO_WIDTH=8 instance: write OUT=0xFFFFFFFF -> reads 0x000000FF, gpio_o=8'hFF; assert rst_n_i low mid-write -> no ack, OUT=0 after release.
